// File: rtl/stage_tl.sv
// TL pipeline stage: DTLB lookup and DTLB/ITLB write handling between EX and the data cache.
// Optional DTLB_THREAD_TAG_EN adds a per-entry thread tag to hit and write matching.
module stage_tl #(
  parameter int unsigned ENTRIES   = 4,
  parameter int unsigned PAGE_BITS = 12,
  parameter int unsigned PADDR_W   = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vm_on,
  input  logic                        hold,
  input  logic                        flush,
  input  logic [1:0]                  ex_thread,
  input  logic                        ex_isvalid,
  input  logic                        ex_itlb_miss,
  input  logic [31:0]                 ex_pc,
  input  logic [31:0]                 ex_data,
  input  logic [31:0]                 ex_mul,
  input  logic [31:0]                 ex_r2,
  input  logic [4:0]                  ex_dst,
  input  logic                        ex_isequal,
  input  logic                        ex_flag_mem,
  input  logic                        ex_flag_store,
  input  logic                        ex_flag_isbyte,
  input  logic                        ex_flag_mul,
  input  logic                        ex_flag_reg,
  input  logic                        ex_flag_jump,
  input  logic                        ex_flag_branch,
  input  logic                        ex_flag_iret,
  input  logic [1:0]                  ex_flag_tlbwrite,
  input  logic [3:0]                  ex_rm4,
  output logic [1:0]                  c_thread,
  output logic                        c_isvalid,
  output logic                        c_itlb_miss,
  output logic [31:0]                 c_pc,
  output logic [31:0]                 c_data,
  output logic [31:0]                 c_mul,
  output logic [31:0]                 c_r2,
  output logic [4:0]                  c_dst,
  output logic                        c_isequal,
  output logic                        c_flag_mem,
  output logic                        c_flag_store,
  output logic                        c_flag_isbyte,
  output logic                        c_flag_mul,
  output logic                        c_flag_reg,
  output logic                        c_flag_jump,
  output logic                        c_flag_branch,
  output logic                        c_flag_iret,
  output logic [3:0]                  c_rm4,
  output logic [PADDR_W-1:0]          c_paddr,
  output logic                        c_dtlb_miss,
  output logic                        itlb_wr_en,
  output logic [31-PAGE_BITS:0]       itlb_wr_vpn,
  output logic [PADDR_W-PAGE_BITS-1:0] itlb_wr_ppn
);

  localparam int unsigned VPN_W = 32 - PAGE_BITS;
  localparam int unsigned PPN_W = PADDR_W - PAGE_BITS;
  localparam int unsigned RR_W  = $clog2(ENTRIES);

  localparam logic [1:0] TlbwDtlb = 2'd1;
  localparam logic [1:0] TlbwItlb = 2'd2;

  logic             r_valid [ENTRIES];
  logic [VPN_W-1:0] r_tag   [ENTRIES];
  logic [PPN_W-1:0] r_ppn   [ENTRIES];
  logic [RR_W-1:0]  r_rr;
`ifdef DTLB_THREAD_TAG_EN
  logic [1:0]       r_thr   [ENTRIES];
`endif

  logic [VPN_W-1:0]   w_vpn;
  logic [PAGE_BITS-1:0] w_off;
  logic               w_hit;
  logic [RR_W-1:0]    w_hit_idx;
  logic [PPN_W-1:0]   w_hit_ppn;
  logic [PADDR_W-1:0] w_paddr;
  logic               w_miss;
  logic               w_load;
  logic               w_commit;
  logic               w_dtlb_we;
  logic               w_itlb_we;

  assign w_vpn = ex_data[31:PAGE_BITS];
  assign w_off = ex_data[PAGE_BITS-1:0];

  // The write rule keeps tags unique, so OR-ing the matching PPNs selects the single hit.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_hit_ppn = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (r_valid[i] && r_tag[i] == w_vpn
`ifdef DTLB_THREAD_TAG_EN
          && r_thr[i] == ex_thread
`endif
         ) begin
        w_hit     = 1'b1;
        w_hit_idx = RR_W'(i);
        w_hit_ppn = w_hit_ppn | r_ppn[i];
      end
    end
  end

  always_comb begin
    w_paddr = '0;
    w_miss  = 1'b0;
    if (!vm_on) begin
      w_paddr = ex_data[PADDR_W-1:0];
    end else if (w_hit) begin
      w_paddr = {w_hit_ppn, w_off};
    end else begin
      w_miss = ex_isvalid & ex_flag_mem;
    end
  end

  // flush overrides hold so the killed slot is always replaced by a bubble.
  assign w_load    = !hold || flush;
  assign w_commit  = ex_isvalid && !hold && !flush;
  assign w_dtlb_we = w_commit && ex_flag_tlbwrite == TlbwDtlb;
  assign w_itlb_we = w_commit && ex_flag_tlbwrite == TlbwItlb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_ppn[i]   <= '0;
`ifdef DTLB_THREAD_TAG_EN
        r_thr[i]   <= '0;
`endif
      end
    end else if (w_dtlb_we) begin
      if (w_hit) begin
        r_ppn[w_hit_idx] <= ex_r2[PPN_W-1:0];
      end else begin
        r_valid[r_rr] <= 1'b1;
        r_tag[r_rr]   <= w_vpn;
        r_ppn[r_rr]   <= ex_r2[PPN_W-1:0];
`ifdef DTLB_THREAD_TAG_EN
        r_thr[r_rr]   <= ex_thread;
`endif
        r_rr          <= r_rr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      itlb_wr_en  <= 1'b0;
      itlb_wr_vpn <= '0;
      itlb_wr_ppn <= '0;
    end else begin
      itlb_wr_en <= w_itlb_we;
      if (w_itlb_we) begin
        itlb_wr_vpn <= w_vpn;
        itlb_wr_ppn <= ex_r2[PPN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_thread       <= '0;
      c_isvalid      <= 1'b0;
      c_itlb_miss    <= 1'b0;
      c_pc           <= '0;
      c_data         <= '0;
      c_mul          <= '0;
      c_r2           <= '0;
      c_dst          <= '0;
      c_isequal      <= 1'b0;
      c_flag_mem     <= 1'b0;
      c_flag_store   <= 1'b0;
      c_flag_isbyte  <= 1'b0;
      c_flag_mul     <= 1'b0;
      c_flag_reg     <= 1'b0;
      c_flag_jump    <= 1'b0;
      c_flag_branch  <= 1'b0;
      c_flag_iret    <= 1'b0;
      c_rm4          <= '0;
      c_paddr        <= '0;
      c_dtlb_miss    <= 1'b0;
    end else if (w_load) begin
      c_thread       <= ex_thread;
      c_isvalid      <= ex_isvalid & ~flush;
      c_itlb_miss    <= ex_itlb_miss;
      c_pc           <= ex_pc;
      c_data         <= ex_data;
      c_mul          <= ex_mul;
      c_r2           <= ex_r2;
      c_dst          <= ex_dst;
      c_isequal      <= ex_isequal;
      c_flag_mem     <= ex_flag_mem;
      c_flag_store   <= ex_flag_store;
      c_flag_isbyte  <= ex_flag_isbyte;
      c_flag_mul     <= ex_flag_mul;
      c_flag_reg     <= ex_flag_reg;
      c_flag_jump    <= ex_flag_jump;
      c_flag_branch  <= ex_flag_branch;
      c_flag_iret    <= ex_flag_iret;
      c_rm4          <= ex_rm4;
      c_paddr        <= w_paddr;
      c_dtlb_miss    <= w_miss & ~flush;
    end
  end

endmodule

// File: tb/tb_stage_tl.sv
// Randomized plus directed bench for stage_tl against a table-based DTLB/ITLB reference model.
module tb_stage_tl;

  logic        clk = 1'b0;
  logic        rst, vm_on, hold, flush;
  logic [1:0]  ex_thread;
  logic        ex_isvalid, ex_itlb_miss;
  logic [31:0] ex_pc, ex_data, ex_mul, ex_r2;
  logic [4:0]  ex_dst;
  logic        ex_isequal;
  logic        ex_flag_mem, ex_flag_store, ex_flag_isbyte, ex_flag_mul;
  logic        ex_flag_reg, ex_flag_jump, ex_flag_branch, ex_flag_iret;
  logic [1:0]  ex_flag_tlbwrite;
  logic [3:0]  ex_rm4;

  logic [1:0]  c_thread;
  logic        c_isvalid, c_itlb_miss;
  logic [31:0] c_pc, c_data, c_mul, c_r2;
  logic [4:0]  c_dst;
  logic        c_isequal;
  logic        c_flag_mem, c_flag_store, c_flag_isbyte, c_flag_mul;
  logic        c_flag_reg, c_flag_jump, c_flag_branch, c_flag_iret;
  logic [3:0]  c_rm4;
  logic [19:0] c_paddr;
  logic        c_dtlb_miss;
  logic        itlb_wr_en;
  logic [19:0] itlb_wr_vpn;
  logic [7:0]  itlb_wr_ppn;

  stage_tl dut (
    .clk(clk), .rst(rst), .vm_on(vm_on), .hold(hold), .flush(flush),
    .ex_thread(ex_thread), .ex_isvalid(ex_isvalid), .ex_itlb_miss(ex_itlb_miss),
    .ex_pc(ex_pc), .ex_data(ex_data), .ex_mul(ex_mul), .ex_r2(ex_r2), .ex_dst(ex_dst),
    .ex_isequal(ex_isequal), .ex_flag_mem(ex_flag_mem), .ex_flag_store(ex_flag_store),
    .ex_flag_isbyte(ex_flag_isbyte), .ex_flag_mul(ex_flag_mul), .ex_flag_reg(ex_flag_reg),
    .ex_flag_jump(ex_flag_jump), .ex_flag_branch(ex_flag_branch),
    .ex_flag_iret(ex_flag_iret), .ex_flag_tlbwrite(ex_flag_tlbwrite), .ex_rm4(ex_rm4),
    .c_thread(c_thread), .c_isvalid(c_isvalid), .c_itlb_miss(c_itlb_miss), .c_pc(c_pc),
    .c_data(c_data), .c_mul(c_mul), .c_r2(c_r2), .c_dst(c_dst), .c_isequal(c_isequal),
    .c_flag_mem(c_flag_mem), .c_flag_store(c_flag_store), .c_flag_isbyte(c_flag_isbyte),
    .c_flag_mul(c_flag_mul), .c_flag_reg(c_flag_reg), .c_flag_jump(c_flag_jump),
    .c_flag_branch(c_flag_branch), .c_flag_iret(c_flag_iret), .c_rm4(c_rm4),
    .c_paddr(c_paddr), .c_dtlb_miss(c_dtlb_miss), .itlb_wr_en(itlb_wr_en),
    .itlb_wr_vpn(itlb_wr_vpn), .itlb_wr_ppn(itlb_wr_ppn)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit rand_thr = 1'b0;

  // Reference DTLB: a plain table plus a round-robin victim counter.
  bit          m_valid [4];
  logic [19:0] m_tag   [4];
  logic [7:0]  m_ppn   [4];
  logic [1:0]  m_thr   [4];
  int          m_rr;

  // Expected registered outputs.
  logic [79:0] e_bundle;
  logic        e_isvalid, e_miss, e_itlb_en;
  logic [31:0] e_pc, e_data;
  logic [4:0]  e_dst;
  logic [19:0] e_paddr, e_ivpn;
  logic [7:0]  e_ippn;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lookup(input logic [19:0] vpn, input logic [1:0] thr);
    int idx = -1;
    for (int i = 0; i < 4; i++) begin
      bit thr_ok = 1'b1;
`ifdef DTLB_THREAD_TAG_EN
      thr_ok = (m_thr[i] == thr);
`endif
      if (m_valid[i] && m_tag[i] == vpn && thr_ok) idx = i;
    end
    return idx;
  endfunction

  task automatic step(input bit r, input bit vm, input bit hd, input bit fl, input bit vld,
                      input bit mem, input logic [1:0] tw, input logic [31:0] d,
                      input logic [31:0] r2);
    int hi;
    bit commit;
    rst = r; vm_on = vm; hold = hd; flush = fl;
    ex_isvalid = vld; ex_flag_mem = mem; ex_flag_tlbwrite = tw; ex_data = d; ex_r2 = r2;
    ex_thread = rand_thr ? 2'($urandom) : 2'd0;
    ex_itlb_miss = 1'($urandom); ex_pc = $urandom; ex_mul = $urandom;
    ex_dst = 5'($urandom); ex_isequal = 1'($urandom); ex_rm4 = 4'($urandom);
    {ex_flag_store, ex_flag_isbyte, ex_flag_mul, ex_flag_reg,
     ex_flag_jump, ex_flag_branch, ex_flag_iret} = 7'($urandom);

    hi = lookup(d[31:12], ex_thread);
    if (r) begin
      e_bundle = '0; e_isvalid = 0; e_miss = 0; e_itlb_en = 0; e_pc = '0; e_data = '0;
      e_dst = '0; e_paddr = '0; e_ivpn = '0; e_ippn = '0; m_rr = 0;
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    end else if (hd && !fl) begin
      e_itlb_en = 1'b0;
    end else begin
      e_bundle = {ex_thread, ex_itlb_miss, ex_mul, ex_r2, ex_isequal, ex_flag_mem,
                  ex_flag_store, ex_flag_isbyte, ex_flag_mul, ex_flag_reg, ex_flag_jump,
                  ex_flag_branch, ex_flag_iret, ex_rm4};
      e_pc = ex_pc; e_data = d; e_dst = ex_dst;
      e_isvalid = vld && !fl;
      if (!vm)          e_paddr = d[19:0];
      else if (hi >= 0) e_paddr = {m_ppn[hi], d[11:0]};
      else              e_paddr = '0;
      e_miss = vm && hi < 0 && vld && mem && !fl;
      commit = vld && !fl;
      e_itlb_en = commit && tw == 2'd2;
      if (e_itlb_en) begin
        e_ivpn = d[31:12]; e_ippn = r2[7:0];
      end
      if (commit && tw == 2'd1) begin
        if (hi >= 0) begin
          m_ppn[hi] = r2[7:0];
        end else begin
          m_valid[m_rr] = 1'b1; m_tag[m_rr] = d[31:12];
          m_ppn[m_rr] = r2[7:0]; m_thr[m_rr] = ex_thread;
          m_rr = (m_rr + 1) % 4;
        end
      end
    end

    @(posedge clk);
    #1;
    check("isvalid", c_isvalid, e_isvalid);
    check("paddr", c_paddr, e_paddr);
    check("dtlb_miss", c_dtlb_miss, e_miss);
    check("itlb_en", itlb_wr_en, e_itlb_en);
    check("itlb_vpn", itlb_wr_vpn, e_ivpn);
    check("itlb_ppn", itlb_wr_ppn, e_ippn);
    check("pc", c_pc, e_pc);
    check("data", c_data, e_data);
    check("dst", c_dst, e_dst);
    check("passthru", {c_thread, c_itlb_miss, c_mul, c_r2, c_isequal, c_flag_mem,
                       c_flag_store, c_flag_isbyte, c_flag_mul, c_flag_reg, c_flag_jump,
                       c_flag_branch, c_flag_iret, c_rm4}, e_bundle);
  endtask

  // Directed-step shorthands: load lookup and DTLB write with vm_on=1, no hold/flush.
  task automatic load(input logic [31:0] d);
    step(0, 1, 0, 0, 1, 1, 2'd0, d, 32'h0);
  endtask

  task automatic dwrite(input logic [31:0] d, input logic [31:0] r2);
    step(0, 1, 0, 0, 1, 0, 2'd1, d, r2);
  endtask

  initial begin
    #1;
    step(1, 0, 0, 0, 0, 0, 2'd0, 32'h0, 32'h0);
    check("rst_paddr", c_paddr, 20'h0);
    check("rst_valid", c_isvalid, 1'b0);

    load(32'h0000_3ABC);
    check("cold_miss", c_dtlb_miss, 1'b1);
    check("cold_valid", c_isvalid, 1'b1);

    dwrite(32'h0000_3000, 32'h5A);
    load(32'h0000_3ABC);
    check("hit_paddr", c_paddr, 20'h5AABC);
    check("hit_nomiss", c_dtlb_miss, 1'b0);

    // Eviction: reset then fill past capacity.
    step(1, 0, 0, 0, 0, 0, 2'd0, 32'h0, 32'h0);
    for (int v = 1; v <= 5; v++) dwrite(32'(v) << 12, 32'(8'h10 + v));
    load(32'h0000_1004);
    check("evict_vpn1", c_dtlb_miss, 1'b1);
    for (int v = 2; v <= 5; v++) begin
      load((32'(v) << 12) | 32'h0FF);
      check("fill_hit", c_paddr, {8'(8'h10 + v), 12'h0FF});
    end
    dwrite(32'h0000_3000, 32'h77);
    load(32'h0000_3010);
    check("rewrite_paddr", c_paddr, 20'h77010);
    dwrite(32'h0000_6000, 32'h66);
    load(32'h0000_2000);
    check("rr_held_evict2", c_dtlb_miss, 1'b1);
    load(32'h0000_3000);
    check("vpn3_kept", c_paddr, 20'h77000);

    step(0, 0, 0, 0, 1, 1, 2'd0, 32'hFFFF_F123, 32'h0);
    check("ident_paddr", c_paddr, 20'hFF123);
    check("ident_nomiss", c_dtlb_miss, 1'b0);

    step(0, 1, 1, 0, 1, 0, 2'd2, 32'h0001_2000, 32'h33);
    check("itlb_held", itlb_wr_en, 1'b0);
    step(0, 1, 0, 0, 1, 0, 2'd2, 32'h0001_2000, 32'h33);
    check("itlb_strobe", itlb_wr_en, 1'b1);
    check("itlb_vpn_c", itlb_wr_vpn, 20'h00012);
    check("itlb_ppn_c", itlb_wr_ppn, 8'h33);
    load(32'h0);
    check("itlb_oneshot", itlb_wr_en, 1'b0);

    step(0, 1, 0, 1, 1, 0, 2'd1, 32'h0000_9000, 32'h99);
    check("flush_kill", c_isvalid, 1'b0);
    load(32'h0000_9000);
    check("flush_nowrite", c_dtlb_miss, 1'b1);

    rand_thr = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? $urandom : {20'($urandom_range(0, 7)), 12'($urandom)};
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0, 1'($urandom),
           2'($urandom), d, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stage_tl.md
Name: stage_tl

Overview:
- Pipeline stage after EX. Consumes the EXTL interface (EX outputs, seen here as `ex_*`) and drives the TLC interface (`c_*`) toward the data-cache stage.
- Holds a small fully-associative DTLB.
- Translates the ALU result of memory ops to a physical address and flags DTLB misses.
- Executes DTLB writes. Forwards ITLB writes to fetch.

Parameters:
- ENTRIES, 4: DTLB entries (power of two, ≥2).
- PAGE_BITS, 12: page offset width.
- PADDR_W, 20: physical address width. PPN width = PADDR_W-PAGE_BITS; VPN width = 32-PAGE_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- vm_on  in  1  1 = translation enabled, 0 = identity map
- hold  in  1  cache stage stall; outputs and state frozen
- flush  in  1  kill the instruction being latched
- ex_thread, ex_isvalid, ex_itlb_miss, ex_pc, ex_data, ex_mul, ex_r2, ex_dst, ex_isequal, ex_flag_{mem,store,isbyte,mul,reg,jump,branch,iret}, ex_flag_tlbwrite, ex_rm4  in  (EXTL types)  EXTL interface
- c_thread, c_isvalid, c_itlb_miss, c_pc, c_data, c_mul, c_r2, c_dst, c_isequal, c_flag_{mem,store,isbyte,mul,reg,jump,branch,iret}, c_rm4  out  (same types)  registered pass-through
- c_paddr  out  PADDR_W  translated address of ex_data
- c_dtlb_miss  out  1  translation failed for a valid memory op
- itlb_wr_en  out  1  one-cycle ITLB write strobe to fetch
- itlb_wr_vpn  out  32-PAGE_BITS  ITLB write VPN
- itlb_wr_ppn  out  PADDR_W-PAGE_BITS  ITLB write PPN

Behaviour:
- Reset and clocking:
  - Clock is clk; reset is synchronous, active-high on rst.
  - Reset: all outputs 0, all DTLB entries invalid, replacement pointer rr = 0.
  - Reset has priority over hold and flush. Reset mid-operation discards any pending write.
- Latency: 1 cycle. All c_* outputs and itlb_wr_* are registered.
- Lookup (combinational on ex_*):
  - vpn = ex_data[31:PAGE_BITS]; off = ex_data[PAGE_BITS-1:0].
  - Hit: a valid entry with tag == vpn. At most one entry matches, guaranteed by the write rule.
  - vm_on=0: c_paddr <= ex_data[PADDR_W-1:0]; c_dtlb_miss <= 0.
  - vm_on=1, hit: c_paddr <= {entry.ppn, off}.
  - vm_on=1, miss: c_paddr <= 0; c_dtlb_miss <= ex_isvalid & ex_flag_mem.
  - c_isvalid is not cleared on a miss; the exception travels with the instruction.
- DTLB write, when ex_isvalid & ex_flag_tlbwrite==dtlb & !hold & !flush:
  - tag = ex_data[31:PAGE_BITS]; ppn = ex_r2[PADDR_W-PAGE_BITS-1:0].
  - If the tag is already present, overwrite that entry and leave rr unchanged.
  - Else write entry rr, set valid, and rr <= (rr+1) mod ENTRIES (wraps).
  - Visible to the instruction in the next cycle.
- ITLB write, when ex_isvalid & ex_flag_tlbwrite==itlb & !hold & !flush:
  - itlb_wr_en <= 1, itlb_wr_vpn <= ex_data[31:PAGE_BITS], itlb_wr_ppn <= ex_r2 low bits.
  - Otherwise itlb_wr_en <= 0.
- hold=1: every register keeps its value, no TLB state changes, itlb_wr_en <= 0.
- flush=1 (hold ignored): c_isvalid <= 0, c_dtlb_miss <= 0, no TLB/ITLB write; other fields load normally.
- No tlbwrite field is forwarded on c_*; the write completes in this stage.

Optional Feature:
- DTLB_THREAD_TAG_EN defined:
  - Each entry also stores a thread tag.
  - Hit requires entry.thread == ex_thread.
  - A write matches an existing entry on {thread, vpn}.
- Undefined: entries are shared by all threads and the thread is ignored for hit and write matching.

Test Plan:
- Reset, then a load with ex_data=0x0000_3ABC, vm_on=1 → c_dtlb_miss=1, c_isvalid=1, c_paddr=0 one cycle later.
- dtlb write ex_data=0x0000_3000, ex_r2=0x5A, then load ex_data=0x0000_3ABC → c_paddr=0x5AABC, c_dtlb_miss=0.
- Five dtlb writes with VPNs 1,2,3,4,5 (ENTRIES=4) → VPN1 is evicted (miss), VPNs 2–5 hit; rewriting VPN3 with PPN 0x77 does not advance rr and the next lookup returns 0x77.
- vm_on=0, load ex_data=0xFFFF_F123 → c_paddr=0xFF123, c_dtlb_miss=0, TLB unchanged.
- itlb write ex_data=0x0001_2000, ex_r2=0x33 → itlb_wr_en=1 for exactly one cycle with vpn=0x00012 and ppn=0x33; with hold=1 during the cycle, no strobe until hold drops.
- flush during a dtlb write → c_isvalid=0 and no entry written; the next lookup of that VPN misses.
